// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core: speculation tracker states and the
// default FIFO entry layout for 32-bit builds.
package mips_core_pkg;

  localparam int SPEC_ADDR_W = 32;
  localparam int SPEC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SPEC,
    RECOVER
  } spec_state_t;

  typedef struct packed {
    logic [SPEC_ADDR_W-1:0] pc;
    logic [SPEC_ADDR_W-1:0] addr;
    logic [SPEC_DATA_W-1:0] pred;
  } spec_entry_t;

endpackage

// File: rtl/value_spec_tracker_if.sv
// MEM/D-cache side signals of the load-value speculation tracker.
// The pipeline side is the master; the tracker is the slave.
interface value_spec_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  miss_valid;
  logic [ADDR_WIDTH-1:0] miss_pc;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  pred_valid;
  logic [DATA_WIDTH-1:0] pred_data;
  logic                  mem_store;
  logic                  fill_valid;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  use_pred;
  logic                  spec_stall;
  logic                  snapshot_take;
  logic                  snapshot_restore;
  logic                  load_pc_we;
  logic [ADDR_WIDTH-1:0] load_pc;
  logic                  flush_all;
  logic                  spec_active;
  logic [OCC_W-1:0]      occupancy;
  logic                  train_valid;
  logic [ADDR_WIDTH-1:0] train_pc;
  logic [DATA_WIDTH-1:0] train_data;
  logic [CNT_W-1:0]      cnt_correct;
  logic [CNT_W-1:0]      cnt_wrong;
  logic                  proto_err;

  modport master (
    output miss_valid, miss_pc, miss_addr, pred_valid, pred_data,
           mem_store, fill_valid, fill_addr, fill_data,
    input  use_pred, spec_stall, snapshot_take, snapshot_restore,
           load_pc_we, load_pc, flush_all, spec_active, occupancy,
           train_valid, train_pc, train_data, cnt_correct, cnt_wrong,
           proto_err
  );

  modport slave (
    input  miss_valid, miss_pc, miss_addr, pred_valid, pred_data,
           mem_store, fill_valid, fill_addr, fill_data,
    output use_pred, spec_stall, snapshot_take, snapshot_restore,
           load_pc_we, load_pc, flush_all, spec_active, occupancy,
           train_valid, train_pc, train_data, cnt_correct, cnt_wrong,
           proto_err
  );

endinterface

// File: rtl/value_spec_tracker_spec_fifo.sv
// Circular buffer of outstanding predicted loads, oldest at the head.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module spec_fifo
  import mips_core_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = spec_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  input  entry_t                       data_i,
  output entry_t                       head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // A clear wins over any push or pop issued in the same cycle.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = ptrInc(wrPtr_q);
      if (doPop)  rdPtr_d = ptrInc(rdPtr_q);
      count_d = count_q + OCC_W'(doPush) - OCC_W'(doPop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/value_spec_tracker.sv
// Load-value speculation controller: lets up to DEPTH predicted misses run
// ahead, verifies fills in order and drives restore/redirect/flush on a miss.
module value_spec_tracker
  import mips_core_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  value_spec_tracker_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] pred;
  } entry_t;

  spec_state_t           state_q, state_d;
  logic [FC_W-1:0]       flushCnt_q, flushCnt_d;
  logic                  restorePend_q, restorePend_d;
  logic [ADDR_WIDTH-1:0] loadPc_q, loadPc_d;
  logic [CNT_W-1:0]      cntCorrect_q, cntCorrect_d;
  logic [CNT_W-1:0]      cntWrong_q, cntWrong_d;
  logic                  protoErr_q, protoErr_d;

  entry_t                head, pushEntry;
  logic                  full, empty;
  logic [OCC_W-1:0]      count, countNext;
  logic                  inRecover, pop, push, addrMatch, dataMatch, mispredict;

  assign inRecover  = (state_q == RECOVER);
  assign pop        = bus.fill_valid & ~empty & ~inRecover;
  assign addrMatch  = (bus.fill_addr == head.addr);
  assign dataMatch  = (bus.fill_data == head.pred);
  assign mispredict = pop & ~(addrMatch & dataMatch);
  assign push       = bus.miss_valid & bus.pred_valid & (~full | pop) &
                      ~inRecover & ~mispredict;
  assign countNext  = count + OCC_W'(push) - OCC_W'(pop);
  assign pushEntry  = '{pc: bus.miss_pc, addr: bus.miss_addr, pred: bus.pred_data};

  spec_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) uFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mispredict),
    .data_i  (pushEntry),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A mismatch latches the load's PC and arms a one-cycle restore/redirect.
  always_comb begin
    state_d       = state_q;
    flushCnt_d    = flushCnt_q;
    restorePend_d = 1'b0;
    loadPc_d      = loadPc_q;
    cntCorrect_d  = cntCorrect_q;
    cntWrong_d    = cntWrong_q;
    protoErr_d    = protoErr_q | (pop & ~addrMatch);
    if (pop && !mispredict && cntCorrect_q != '1) cntCorrect_d = cntCorrect_q + CNT_W'(1);
    if (mispredict && cntWrong_q != '1) cntWrong_d = cntWrong_q + CNT_W'(1);
    unique case (state_q)
      IDLE, SPEC: begin
        if (mispredict) begin
          state_d       = RECOVER;
          flushCnt_d    = FC_W'(FLUSH_CYCLES - 1);
          restorePend_d = 1'b1;
          loadPc_d      = head.pc;
        end else begin
          state_d = (countNext != '0) ? SPEC : IDLE;
        end
      end
      RECOVER: begin
        if (flushCnt_q == '0) state_d = IDLE;
        else flushCnt_d = flushCnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flushCnt_q    <= '0;
      restorePend_q <= 1'b0;
      loadPc_q      <= '0;
      cntCorrect_q  <= '0;
      cntWrong_q    <= '0;
      protoErr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flushCnt_q    <= flushCnt_d;
      restorePend_q <= restorePend_d;
      loadPc_q      <= loadPc_d;
      cntCorrect_q  <= cntCorrect_d;
      cntWrong_q    <= cntWrong_d;
      protoErr_q    <= protoErr_d;
    end
  end

  assign bus.use_pred         = push;
  assign bus.snapshot_take    = push & empty;
  assign bus.spec_stall       = inRecover |
                                (bus.miss_valid & ~bus.pred_valid & ~empty) |
                                (bus.miss_valid & bus.pred_valid & full & ~pop) |
                                (bus.mem_store & ~empty);
  assign bus.snapshot_restore = restorePend_q;
  assign bus.load_pc_we       = restorePend_q;
  assign bus.load_pc          = loadPc_q;
  assign bus.flush_all        = inRecover;
  assign bus.spec_active      = ~empty;
  assign bus.occupancy        = count;
  assign bus.train_valid      = pop;
  assign bus.train_pc         = pop ? head.pc : '0;
  assign bus.train_data       = pop ? bus.fill_data : '0;
  assign bus.cnt_correct      = cntCorrect_q;
  assign bus.cnt_wrong        = cntWrong_q;
  assign bus.proto_err        = protoErr_q;

endmodule

// File: tb/tb_value_spec_tracker.sv
// Directed bench for value_spec_tracker (DEPTH=4, FLUSH_CYCLES=2):
// inputs change on negedge, outputs are checked 1ns later.
module tb_value_spec_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  value_spec_tracker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .CNT_W(16)) bus ();

  value_spec_tracker #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [31:0] mpc, input logic [31:0] maddr,
                               input logic pv, input logic [31:0] pd, input logic st,
                               input logic fv, input logic [31:0] faddr, input logic [31:0] fd);
    @(negedge clk);
    bus.miss_valid = mv;
    bus.miss_pc    = mpc;
    bus.miss_addr  = maddr;
    bus.pred_valid = pv;
    bus.pred_data  = pd;
    bus.mem_store  = st;
    bus.fill_valid = fv;
    bus.fill_addr  = faddr;
    bus.fill_data  = fd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic predMiss(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] pd);
    applyStimulus(1, pc, addr, 1, pd, 0, 0, 0, 0);
  endtask

  task automatic fillOnly(input logic [31:0] addr, input logic [31:0] d);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, addr, d);
  endtask

  initial begin
    bus.miss_valid = 0; bus.miss_pc = 0; bus.miss_addr = 0; bus.pred_valid = 0;
    bus.pred_data = 0; bus.mem_store = 0; bus.fill_valid = 0; bus.fill_addr = 0;
    bus.fill_data = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_occupancy", bus.occupancy, 0);
    checkOutput("rst_flush", bus.flush_all, 0);
    checkOutput("rst_load_pc", bus.load_pc, 0);
    checkOutput("rst_cnt_correct", bus.cnt_correct, 0);
    checkOutput("rst_proto_err", bus.proto_err, 0);
    rst_n = 1'b1;

    // Stray fill with nothing outstanding is ignored
    fillOnly(32'h1000, 32'hAB);
    checkOutput("stray_train_valid", bus.train_valid, 0);

    // 1: single correct prediction
    predMiss(32'h0040_0100, 32'h1000, 32'hAB);
    checkOutput("t1_use_pred", bus.use_pred, 1);
    checkOutput("t1_snapshot_take", bus.snapshot_take, 1);
    checkOutput("t1_spec_stall", bus.spec_stall, 0);
    idleCycle();
    checkOutput("t1_occupancy", bus.occupancy, 1);
    checkOutput("t1_spec_active", bus.spec_active, 1);
    idleCycle();
    fillOnly(32'h1000, 32'hAB);
    checkOutput("t1_train_valid", bus.train_valid, 1);
    checkOutput("t1_train_pc", bus.train_pc, 32'h0040_0100);
    checkOutput("t1_train_data", bus.train_data, 32'hAB);
    idleCycle();
    checkOutput("t1_cnt_correct", bus.cnt_correct, 1);
    checkOutput("t1_occupancy_end", bus.occupancy, 0);
    checkOutput("t1_no_flush", bus.flush_all, 0);
    checkOutput("t1_cnt_stat_clean", bus.cnt_correct, 16'd1);

    // 2: misprediction and recovery
    predMiss(32'h0040_0200, 32'h2000, 32'h5);
    checkOutput("t2_snapshot_take", bus.snapshot_take, 1);
    fillOnly(32'h2000, 32'h6);
    checkOutput("t2_train_valid", bus.train_valid, 1);
    checkOutput("t2_train_data", bus.train_data, 32'h6);
    checkOutput("t2_restore_early", bus.snapshot_restore, 0);
    idleCycle();
    checkOutput("t2_restore", bus.snapshot_restore, 1);
    checkOutput("t2_load_pc_we", bus.load_pc_we, 1);
    checkOutput("t2_load_pc", bus.load_pc, 32'h0040_0200);
    checkOutput("t2_flush1", bus.flush_all, 1);
    checkOutput("t2_cnt_wrong", bus.cnt_wrong, 1);
    checkOutput("t2_occupancy", bus.occupancy, 0);
    checkOutput("t2_stall", bus.spec_stall, 1);
    predMiss(32'h0040_0300, 32'h2100, 32'h9);
    checkOutput("t2_restore_done", bus.snapshot_restore, 0);
    checkOutput("t2_flush2", bus.flush_all, 1);
    checkOutput("t2_recover_no_use", bus.use_pred, 0);
    idleCycle();
    checkOutput("t2_flush_off", bus.flush_all, 0);
    checkOutput("t2_no_alloc", bus.occupancy, 0);
    checkOutput("t2_stall_off", bus.spec_stall, 0);

    // 3: fill the tracker, 5th miss stalls until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      predMiss(32'h0050_0000 + 4 * i, 32'h3000 + 4 * i, 32'h100 + i);
      checkOutput("t3_use_pred", bus.use_pred, 1);
      checkOutput("t3_snapshot", bus.snapshot_take, (i == 0) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      predMiss(32'h0050_0010, 32'h3010, 32'h104);
      checkOutput("t3_full_occ", bus.occupancy, 4);
      checkOutput("t3_full_stall", bus.spec_stall, 1);
      checkOutput("t3_full_no_use", bus.use_pred, 0);
    end
    applyStimulus(1, 32'h0050_0010, 32'h3010, 1, 32'h104, 0, 1, 32'h3000, 32'h100);
    checkOutput("t3_popush_use", bus.use_pred, 1);
    checkOutput("t3_popush_stall", bus.spec_stall, 0);
    checkOutput("t3_popush_snap", bus.snapshot_take, 0);
    for (int i = 1; i < 5; i++) begin
      fillOnly(32'h3000 + 4 * i, 32'h100 + i);
      if (i == 1) checkOutput("t3_occ_held", bus.occupancy, 4);
      checkOutput("t3_drain_pc", bus.train_pc, 32'h0050_0000 + 4 * i);
    end
    idleCycle();
    checkOutput("t3_occ_end", bus.occupancy, 0);
    checkOutput("t3_cnt_correct", bus.cnt_correct, 6);

    // 4: store barrier and unpredicted miss behaviour
    applyStimulus(1, 32'h0060_0100, 32'h4100, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_passive_stall", bus.spec_stall, 0);
    checkOutput("t4_passive_use", bus.use_pred, 0);
    predMiss(32'h0060_0000, 32'h4000, 32'h11);
    predMiss(32'h0060_0004, 32'h4004, 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t4_store_stall", bus.spec_stall, 1);
    checkOutput("t4_occ", bus.occupancy, 2);
    applyStimulus(1, 32'h0060_0200, 32'h4200, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_unpred_stall", bus.spec_stall, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h4000, 32'h11);
    checkOutput("t4_store_fill1", bus.spec_stall, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h4004, 32'h22);
    checkOutput("t4_store_fill2", bus.spec_stall, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t4_store_free", bus.spec_stall, 0);
    checkOutput("t4_cnt_correct", bus.cnt_correct, 8);

    // 5a: mismatched fill with a simultaneous predicted miss
    predMiss(32'h0070_0000, 32'h5000, 32'h77);
    applyStimulus(1, 32'h0070_0004, 32'h5004, 1, 32'h99, 0, 1, 32'h5000, 32'h78);
    checkOutput("t5a_use_pred", bus.use_pred, 0);
    checkOutput("t5a_snapshot", bus.snapshot_take, 0);
    checkOutput("t5a_train_valid", bus.train_valid, 1);
    idleCycle();
    checkOutput("t5a_restore", bus.snapshot_restore, 1);
    checkOutput("t5a_load_pc", bus.load_pc, 32'h0070_0000);
    checkOutput("t5a_occ", bus.occupancy, 0);
    checkOutput("t5a_cnt_wrong", bus.cnt_wrong, 2);
    checkOutput("t5a_proto_err", bus.proto_err, 0);
    idleCycle();
    idleCycle();
    checkOutput("t5a_flush_off", bus.flush_all, 0);
    checkOutput("t5a_occ_end", bus.occupancy, 0);

    // 5b: fill address mismatch with matching data
    predMiss(32'h0080_0000, 32'h6000, 32'h55);
    fillOnly(32'h6004, 32'h55);
    checkOutput("t5b_train_valid", bus.train_valid, 1);
    idleCycle();
    checkOutput("t5b_proto_err", bus.proto_err, 1);
    checkOutput("t5b_restore", bus.snapshot_restore, 1);
    checkOutput("t5b_load_pc", bus.load_pc, 32'h0080_0000);
    checkOutput("t5b_cnt_wrong", bus.cnt_wrong, 3);

    // 5c: reset in the middle of recovery
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5c_flush", bus.flush_all, 0);
    checkOutput("t5c_stall", bus.spec_stall, 0);
    checkOutput("t5c_proto_err", bus.proto_err, 0);
    checkOutput("t5c_load_pc", bus.load_pc, 0);
    checkOutput("t5c_cnt_wrong", bus.cnt_wrong, 0);
    checkOutput("t5c_cnt_correct", bus.cnt_correct, 0);
    checkOutput("t5c_restore", bus.snapshot_restore, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    checkOutput("t5c_post_restore", bus.snapshot_restore, 0);
    checkOutput("t5c_post_flush", bus.flush_all, 0);
    checkOutput("t5c_post_occ", bus.occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/value_spec_tracker.md
# value_spec_tracker

Parametrised load-value speculation controller for the MIPS pipeline. It sits beside the hazard controller between MEM and the D-cache. It lets up to DEPTH D-cache read misses run ahead on predicted values, and checks each fill against its prediction in program order. On a mismatch it triggers a register-snapshot restore, a PC reload and a pipeline flush. Compared with single-outstanding value prediction, it adds configurable depth, a store barrier, in-order verification and accuracy counters.

## Interface
- DATA_WIDTH, 32, load data width
- ADDR_WIDTH, 32, PC and address width
- DEPTH, 4, maximum outstanding predicted loads (≥1)
- FLUSH_CYCLES, 2, cycles `flush_all` is held during recovery (≥1)
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  first cycle of a D-cache read miss in MEM
- miss_pc, miss_addr  in  ADDR_WIDTH  PC and address of the missing load
- pred_valid  in  1  predictor has a confident value for miss_pc
- pred_data  in  DATA_WIDTH  predicted value
- mem_store  in  1  a store is in MEM this cycle
- fill_valid  in  1  D-cache returns data for the oldest outstanding miss
- fill_addr  in  ADDR_WIDTH  address of the fill
- fill_data  in  DATA_WIDTH  actual loaded value
- use_pred  out  1  MEM takes pred_data instead of waiting for the fill
- spec_stall  out  1  stall IF through MEM
- snapshot_take  out  1  capture the register file (1-cycle pulse)
- snapshot_restore  out  1  restore the register file (1-cycle pulse)
- load_pc_we  out  1  redirect fetch (1-cycle pulse)
- load_pc  out  ADDR_WIDTH  redirect target (PC of the mispredicted load)
- flush_all  out  1  flush every pipeline register
- spec_active  out  1  one or more entries are outstanding
- occupancy  out  $clog2(DEPTH+1)  number of entries
- train_valid  out  1  one training update for the predictor
- train_pc  out  ADDR_WIDTH  PC being trained
- train_data  out  DATA_WIDTH  actual value being trained
- cnt_correct, cnt_wrong  out  CNT_W  verified and mispredicted loads
- proto_err  out  1  sticky: fill_addr did not match the head entry address

## Operation
- **FSM states**
  - IDLE: occupancy 0.
  - SPEC: occupancy ≥1.
  - RECOVER: flush countdown running.
- **push** = miss_valid & pred_valid & (~full | pop) & state≠RECOVER & ~mispredict.
  - Writes {pc, addr, pred_data} to the tail.
  - `use_pred` = push, combinational.
  - `snapshot_take` = push & occupancy==0, combinational.
  - `snapshot_take` never fires when a pop in the same cycle empties the tracker.
- **pop** = fill_valid & occupancy≠0 & state≠RECOVER. The fill is compared with the head entry, both data and address.
  - Match: retire the head, increment cnt_correct, pulse train_*.
  - Mismatch: raise `mispredict`. Increment cnt_wrong and pulse train_* with fill_data. Latch the head pc into load_pc and clear all entries. Go to RECOVER.
  - Any push in the same cycle is dropped.
  - If fill_addr ≠ head addr, set proto_err and treat the fill as a mismatch.
- fill_valid with occupancy 0 is ignored. It belongs to an untracked miss.
- **spec_stall** is asserted (combinational) when any of these holds:
  - state==RECOVER
  - miss_valid & ~pred_valid & occupancy≠0, so unpredicted misses wait until the tracker drains
  - miss_valid & pred_valid & full & ~pop
  - mem_store & spec_active, so no speculative store is committed
- An unpredicted miss with occupancy 0 is passive: spec_stall stays 0 and the normal dc_miss path handles it.
- **RECOVER**
  - The cycle after entry, snapshot_restore and load_pc_we pulse together.
  - flush_all is high for FLUSH_CYCLES cycles starting that cycle.
  - Then go to IDLE. miss_valid and fill_valid are ignored throughout.
- Counters saturate at 2^CNT_W−1.

## Timing
- Every output resets to 0; state resets to IDLE; the FIFO pointers and proto_err are cleared.
- Reset asserted mid-speculation or mid-recovery discards everything with no restore pulse.
- Push, pop and state updates take effect at posedge clk.
- use_pred, snapshot_take and spec_stall are same-cycle combinational. train_* is same-cycle with the pop.
- Mispredict-to-redirect latency is 1 cycle. load_pc is stable while load_pc_we is high.
- A simultaneous pop and push when full is legal and occupancy holds.
- The pointers wrap modulo DEPTH. DEPTH does not need to be a power of 2.

## Structure
- Shared package mips_core_pkg:
  - `spec_state_t` enum {IDLE, SPEC, RECOVER}
  - `spec_entry_t` struct {pc, addr, pred}
- Sub-module `spec_fifo`: a DEPTH-entry circular buffer holding spec_entry_t.
  - Ports: push, pop, clear, head, full, empty, count.
  - clear has priority over push.
- The FSM, comparison and counters live in the top level.

## Test plan
1. Single correct prediction:
   - Stimulus: miss pc=0x400100, addr=0x1000, pred=0xAB. Three cycles later, fill 0xAB at addr 0x1000.
   - Response: use_pred=1 and snapshot_take=1 on the miss cycle. cnt_correct=1. No flush. Tracker returns to IDLE.
2. Misprediction:
   - Stimulus: pred=0x5, fill=0x6.
   - Response: on the following cycle, snapshot_restore=1 and load_pc_we=1 with load_pc=miss pc. flush_all is high for 2 cycles. cnt_wrong=1, train_data=0x6. Occupancy goes to 0.
3. Fill the tracker (DEPTH=4):
   - Stimulus: 4 predicted misses, then a 5th.
   - Response: the 5th sees spec_stall=1 until a matching fill arrives. It is then pushed in the same cycle as the pop.
4. Store barrier:
   - Stimulus: occupancy 2, mem_store=1.
   - Response: spec_stall=1 until the second fill matches.
5. Simultaneous events and edge cases:
   - A mismatched fill and a new predicted miss in the same cycle: use_pred=0 and the miss is not allocated.
   - A fill with the wrong addr: proto_err=1 and recovery is triggered.
   - rst_n asserted during RECOVER: all outputs are 0 immediately.
